// File: rtl/matrix_transpose_arbiter.sv
// Round-robin, whole-matrix arbiter that shares one streaming transpose unit and routes results back to each owner.
// Optional perf counters are enabled by defining MATRIX_TRANSPOSE_ARBITER_PERF_EN; otherwise perf_* are tied to 0.
module matrix_transpose_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int TOTAL_DIM0   = 4,
  parameter int TOTAL_DIM1   = 4,
  parameter int COMPUTE_DIM0 = 2,
  parameter int COMPUTE_DIM1 = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int TAG_DEPTH    = 2,
  localparam int BEAT_W = DATA_WIDTH * COMPUTE_DIM0 * COMPUTE_DIM1,
  localparam int BEATS  = (TOTAL_DIM0 / COMPUTE_DIM0) * (TOTAL_DIM1 / COMPUTE_DIM1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*BEAT_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BEAT_W-1:0]         tp_in_data,
  output logic                      tp_in_valid,
  input  logic                      tp_in_ready,
  input  logic [BEAT_W-1:0]         tp_out_data,
  input  logic                      tp_out_valid,
  output logic                      tp_out_ready,
  output logic [BEAT_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [31:0]               perf_matrices,
  output logic [31:0]               perf_stall_cycles
);

  localparam int unsigned NR    = NUM_REQ;
  localparam int unsigned TD    = TAG_DEPTH;
  localparam int          CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int          GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          PW    = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int          OW    = $clog2(TAG_DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [GW-1:0]    tag_mem_q [TAG_DEPTH];
  logic [GW-1:0]    tag_mem_d [TAG_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;

  logic          tag_full, tag_empty;
  logic          sel_found, push, pop, in_hs, out_hs;
  logic [GW-1:0] sel_idx, cand, owner;

  assign tag_full  = (occ_q == OW'(TAG_DEPTH));
  assign tag_empty = (occ_q == '0);
  assign owner     = tag_mem_q[rd_ptr_q];

  // First valid requester at or after rr_ptr, with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      cand = GW'((32'(rr_ptr_q) + i) % NR);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    tp_in_data  = req_data[grant_q*BEAT_W +: BEAT_W];
    tp_in_valid = (state_q == S_STREAM) && req_valid[grant_q];
    req_ready   = '0;
    if (state_q == S_STREAM) req_ready[grant_q] = tp_in_ready;
  end

  assign in_hs = tp_in_valid && tp_in_ready;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    in_cnt_d = in_cnt_q;
    push     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found && !tag_full) begin
          grant_d  = sel_idx;
          push     = 1'b1;
          in_cnt_d = '0;
          state_d  = S_STREAM;
        end
      end
      default: begin
        if (in_hs) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == LAST_BEAT) begin
            state_d  = S_IDLE;
            rr_ptr_d = (32'(grant_q) == NR - 1) ? '0 : grant_q + GW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    rsp_valid    = '0;
    tp_out_ready = 1'b0;
    if (!tag_empty) begin
      rsp_valid[owner] = tp_out_valid;
      tp_out_ready     = rsp_ready[owner];
    end
  end

  assign rsp_data  = tp_out_data;
  assign out_hs    = tp_out_valid && tp_out_ready;
  assign pop       = out_hs && (out_cnt_q == LAST_BEAT);
  assign out_cnt_d = pop ? '0 : (out_hs ? out_cnt_q + CNT_W'(1) : out_cnt_q);

  always_comb begin
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    if (push) begin
      tag_mem_d[wr_ptr_q] = sel_idx;
      wr_ptr_d = (32'(wr_ptr_q) == TD - 1) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = (32'(rd_ptr_q) == TD - 1) ? '0 : rd_ptr_q + PW'(1);
    // A push and pop in the same cycle leave occupancy unchanged.
    if (push && !pop)      occ_d = occ_q + OW'(1);
    else if (pop && !push) occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      for (int unsigned i = 0; i < TD; i++) tag_mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      tag_mem_q <= tag_mem_d;
    end
  end

`ifdef MATRIX_TRANSPOSE_ARBITER_PERF_EN
  logic [31:0] perf_matrices_q, perf_matrices_d;
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    perf_matrices_d     = perf_matrices_q;
    perf_stall_cycles_d = perf_stall_cycles_q;
    if (pop && (perf_matrices_q != '1)) perf_matrices_d = perf_matrices_q + 32'd1;
    if (tp_in_valid && !tp_in_ready && (perf_stall_cycles_q != '1))
      perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_matrices_q     <= '0;
      perf_stall_cycles_q <= '0;
    end else begin
      perf_matrices_q     <= perf_matrices_d;
      perf_stall_cycles_q <= perf_stall_cycles_d;
    end
  end

  assign perf_matrices     = perf_matrices_q;
  assign perf_stall_cycles = perf_stall_cycles_q;
`else
  assign perf_matrices     = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_matrix_transpose_arbiter.sv
// Scoreboard bench for matrix_transpose_arbiter with a behavioural transpose unit (returns ~beat, in order).
module tb_matrix_transpose_arbiter;
  localparam int NUM_REQ = 2;
  localparam int BEAT_W  = 32;
  localparam int BEATS   = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ*BEAT_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [BEAT_W-1:0]         tp_in_data, tp_out_data, rsp_data;
  logic                      tp_in_valid, tp_in_ready, tp_out_valid, tp_out_ready;
  logic [31:0]               perf_matrices, perf_stall_cycles;

  matrix_transpose_arbiter #(
    .NUM_REQ(2), .TOTAL_DIM0(4), .TOTAL_DIM1(4),
    .COMPUTE_DIM0(2), .COMPUTE_DIM1(2), .DATA_WIDTH(8), .TAG_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .tp_in_data(tp_in_data), .tp_in_valid(tp_in_valid), .tp_in_ready(tp_in_ready),
    .tp_out_data(tp_out_data), .tp_out_valid(tp_out_valid), .tp_out_ready(tp_out_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .perf_matrices(perf_matrices), .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                owner;
    logic [BEAT_W-1:0] data;
  } exp_t;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int beats_left[NUM_REQ], sent[NUM_REQ], pause_at[NUM_REQ], pause_len[NUM_REQ], pause_rem[NUM_REQ];
  logic paused[NUM_REQ];
  exp_t sb[$];
  logic [BEAT_W-1:0] tp_q[$];
  int order[$], first_cyc[$], last_cyc[$], pop_cyc[$];
  int cur_beats, cur_owner, in_hs_total, out_beats, out_total, stall_rem;
  logic saw_rsp1, stall_arm, rsp_en;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] beat_of(input int i, input int k);
    return {8'(i + 1), 8'(k), 16'((k * 945) ^ 23130)};
  endfunction

  task automatic clear_tb();
    for (int i = 0; i < NUM_REQ; i++) begin
      beats_left[i] = 0; sent[i] = 0; pause_at[i] = -1; pause_len[i] = 0; pause_rem[i] = 0;
    end
    sb.delete(); tp_q.delete(); order.delete();
    first_cyc.delete(); last_cyc.delete(); pop_cyc.delete();
    cur_beats = 0; cur_owner = 0; in_hs_total = 0; out_beats = 0; out_total = 0;
    stall_rem = 0; stall_arm = 1'b0; saw_rsp1 = 1'b0; rsp_en = 1'b1;
  endtask

  // Drive requesters and the transpose model just after each rising edge.
  initial begin
    req_valid = '0; req_data = '0; tp_in_ready = 1'b0;
    tp_out_valid = 1'b0; tp_out_data = '0; rsp_ready = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        paused[i] = 1'b0;
        if (pause_rem[i] > 0) begin paused[i] = 1'b1; pause_rem[i]--; end
        req_valid[i] = (beats_left[i] > 0) && !paused[i];
        req_data[i*BEAT_W +: BEAT_W] = beat_of(i, sent[i]);
      end
      tp_in_ready = (stall_rem == 0);
      if (stall_rem > 0) stall_rem--;
      tp_out_valid = (tp_q.size() > 0);
      tp_out_data  = (tp_q.size() > 0) ? tp_q[0] : '0;
      rsp_ready    = rsp_en ? '1 : '0;
    end
  end

  // Values at the falling edge are what the next rising edge will act on.
  task automatic monitor();
    int nhs;
    exp_t e;
    logic [NUM_REQ-1:0] ov;
    nhs = 0;
    check("ready_onehot", $countones(req_ready) <= 1, 1);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        nhs++;
        check("tp_in_data", tp_in_data, beat_of(i, sent[i]));
        if (cur_beats == 0) begin order.push_back(i); first_cyc.push_back(cyc); end
        else check("same_owner", i, cur_owner);
        cur_owner = i;
        cur_beats++;
        if (cur_beats == BEATS) begin cur_beats = 0; last_cyc.push_back(cyc); end
        sb.push_back('{i, ~beat_of(i, sent[i])});
        sent[i]++; beats_left[i]--; in_hs_total++;
        if (sent[i] == pause_at[i]) pause_rem[i] = pause_len[i];
        if (stall_arm && in_hs_total == 1) begin stall_rem = 3; stall_arm = 1'b0; end
      end
    end
    check("tp_in_hs", tp_in_valid && tp_in_ready, nhs == 1);
    if (tp_in_valid && tp_in_ready) tp_q.push_back(~tp_in_data);
    if (paused[0] && req_valid[1]) check("held_grant_ready1", req_ready[1], 0);
    if (rsp_valid[1]) saw_rsp1 = 1'b1;
    if (|(rsp_valid & rsp_ready)) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sb.pop_front();
        ov = '0;
        ov[e.owner] = 1'b1;
        check("rsp_valid", rsp_valid, ov);
        check("rsp_data", rsp_data, e.data);
        out_total++; out_beats++;
        if (out_beats == BEATS) begin out_beats = 0; pop_cyc.push_back(cyc); end
      end
    end
    check("tp_out_hs", tp_out_valid && tp_out_ready, |(rsp_valid & rsp_ready));
    if (tp_out_valid && tp_out_ready && tp_q.size() > 0) void'(tp_q.pop_front());
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) monitor();
  end

  function automatic logic all_done();
    logic d;
    d = (sb.size() == 0) && (tp_q.size() == 0);
    for (int i = 0; i < NUM_REQ; i++) if (beats_left[i] != 0) d = 1'b0;
    return d;
  endfunction

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!all_done() && n < budget) begin @(negedge clk); #1; n++; end
    if (!all_done()) check("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n;
    n = 0;
    while (in_hs_total < target && n < budget) begin @(negedge clk); #1; n++; end
    check("hs_reached", in_hs_total >= target, 1);
  endtask

  task automatic check_order(input string tag, input int exp_q[$]);
    check({tag, "_count"}, order.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < order.size(); k++) check(tag, order[k], exp_q[k]);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_tb();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    clear_tb();
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_tp_in_valid", tp_in_valid, 0);
    check("rst_tp_out_ready", tp_out_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_perf_matrices", perf_matrices, 0);
    check("rst_perf_stall", perf_stall_cycles, 0);

    // Single requester.
    do_reset();
    beats_left[0] = 4;
    wait_done(60);
    check("single_in_beats", in_hs_total, 4);
    check("single_out_beats", out_total, 4);
    check_order("single_order", '{0});
    check("single_no_rsp1", saw_rsp1, 0);
    check("single_tag_empty", tp_out_ready, 0);

    // Contention: round-robin with one idle cycle between matrices.
    do_reset();
    beats_left[0] = 8; beats_left[1] = 8;
    wait_done(200);
    check_order("contend_order", '{0, 1, 0, 1});
    for (int k = 1; k < first_cyc.size() && k <= last_cyc.size(); k++)
      check("contend_bubble", first_cyc[k] - last_cyc[k-1], 2);
    check("contend_out_beats", out_total, 16);

    // Granted requester pauses mid-matrix; grant is held.
    do_reset();
    beats_left[0] = 4; beats_left[1] = 4;
    pause_at[0] = 2; pause_len[0] = 5;
    wait_done(120);
    check_order("stall_order", '{0, 1});
    check("stall_out_beats", out_total, 8);

    // Tag FIFO full: third matrix waits for a pop.
    do_reset();
    rsp_en = 1'b0;
    beats_left[0] = 8; beats_left[1] = 4;
    wait_hs(8, 100);
    repeat (10) @(negedge clk);
    #1;
    check("full_no_more_hs", in_hs_total, 8);
    check("full_req_ready", req_ready, 0);
    check("full_tp_out_ready", tp_out_ready, 0);
    rsp_en = 1'b1;
    wait_done(200);
    check_order("full_order", '{0, 1, 0});
    if (first_cyc.size() == 3 && pop_cyc.size() >= 1)
      check("full_grant_after_pop", first_cyc[2] - pop_cyc[0], 2);
    else check("full_grant_after_pop_seen", 0, 1);

    // Asynchronous reset mid-matrix.
    do_reset();
    beats_left[0] = 4;
    wait_done(60);
    beats_left[1] = 4;
    while (sent[1] < 2 && in_hs_total < 100) begin @(negedge clk); #1; end
    check("prerst_streaming", tp_in_valid, 1);
    rst = 1'b0;
    #1;
    check("arst_req_ready", req_ready, 0);
    check("arst_tp_in_valid", tp_in_valid, 0);
    check("arst_tp_out_ready", tp_out_ready, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    do_reset();
    beats_left[0] = 4; beats_left[1] = 4;
    wait_done(120);
    check_order("arst_order", '{0, 1});

    // Perf counters: 2 matrices with 3 stall cycles.
    do_reset();
    beats_left[0] = 8;
    stall_arm = 1'b1;
    wait_done(120);
`ifdef MATRIX_TRANSPOSE_ARBITER_PERF_EN
    check("perf_stall_cycles", perf_stall_cycles, 3);
    check("perf_matrices", perf_matrices, 2);
`else
    check("perf_stall_cycles_off", perf_stall_cycles, 0);
    check("perf_matrices_off", perf_matrices, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
